fft_frame_loader: RTL

- Consumer side of the Hamming window stage output.
- Captures pointer-addressed windowed samples (`hamming_sample_o`, `frame_ptr_o`, `out_valid_o`, `done_o`) into a ping-pong frame store.
- Streams each completed frame to the FFT as NFFT_SIZE samples, with a valid/ready handshake and zero-padding from FRAME_SIZE up to NFFT_SIZE.
- Decouples the windowing stage from FFT back-pressure so the next frame can be windowed while the previous one drains.

---
 rtl/fft_frame_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_loader.sv
// Ping-pong frame store between the Hamming window stage and the FFT; streams NFFT_SIZE
// samples per frame with zero-padding. Define FFT_FRAME_LOADER_BITREV_EN for bit-reversed emission.
module fft_frame_loader #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_SIZE   = 400,
    parameter int NFFT_SIZE    = 512,
    parameter int PTR_WIDTH    = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid_i,
    input  logic        [PTR_WIDTH-1:0]    in_ptr_i,
    input  logic signed [SAMPLE_WIDTH-1:0] in_sample_i,
    input  logic                           in_done_i,
    output logic                           in_ready_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic        [PTR_WIDTH-1:0]    out_index_o,
    output logic signed [SAMPLE_WIDTH-1:0] out_data_o,
    output logic                           out_last_o,
    output logic        [15:0]             frame_cnt_o,
    output logic                           overflow_o
);

    localparam logic [PTR_WIDTH:0]   LP_FRAME = (PTR_WIDTH+1)'(FRAME_SIZE);
    localparam logic [PTR_WIDTH-1:0] LP_LAST  = PTR_WIDTH'(NFFT_SIZE - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    function automatic logic [PTR_WIDTH-1:0] f_order(input logic [PTR_WIDTH-1:0] k);
        logic [PTR_WIDTH-1:0] r;
`ifdef FFT_FRAME_LOADER_BITREV_EN
        for (int i = 0; i < PTR_WIDTH; i++) r[i] = k[PTR_WIDTH-1-i];
`else
        r = k;
`endif
        return r;
    endfunction

    logic [SAMPLE_WIDTH-1:0] r_mem [2][FRAME_SIZE];
    logic [FRAME_SIZE-1:0]   r_bitmap [2];
    logic [1:0]              r_bank_full;
    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic                    r_overflow;

    state_t                  r_state;
    logic [PTR_WIDTH-1:0]    r_k;
    logic                    r_out_valid;
    logic [PTR_WIDTH-1:0]    r_out_index;
    logic [SAMPLE_WIDTH-1:0] r_out_data;
    logic                    r_out_last;
    logic [15:0]             r_frame_cnt;

    logic                    w_in_ready;
    logic                    w_wr_en;
    logic                    w_done_acc;
    logic                    w_handshake;

    state_t                  w_state_nxt;
    logic [PTR_WIDTH-1:0]    w_k_nxt;
    logic                    w_valid_nxt;
    logic                    w_load;
    logic                    w_load_bank;
    logic                    w_frame_done;
    logic [PTR_WIDTH-1:0]    w_rd_idx;
    logic [SAMPLE_WIDTH-1:0] w_rd_data;

    assign w_in_ready  = !r_bank_full[r_wr_bank];
    assign w_wr_en     = in_valid_i && w_in_ready && ({1'b0, in_ptr_i} < LP_FRAME);
    assign w_done_acc  = in_done_i && w_in_ready;
    assign w_handshake = r_out_valid && out_ready_i;

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_bank][in_ptr_i] <= in_sample_i;
    end

    // The bank being drained is always full, so write-side and read-side updates never hit the same bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitmap[0] <= '0;
            r_bitmap[1] <= '0;
            r_bank_full <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_en) r_bitmap[r_wr_bank][in_ptr_i] <= 1'b1;
            if (w_frame_done) begin
                r_bitmap[r_rd_bank]    <= '0;
                r_bank_full[r_rd_bank] <= 1'b0;
            end
            if (w_done_acc) begin
                r_bank_full[r_wr_bank] <= 1'b1;
                r_wr_bank              <= ~r_wr_bank;
            end
            if ((in_valid_i || in_done_i) && !w_in_ready) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_valid_nxt  = r_out_valid;
        w_load       = 1'b0;
        w_load_bank  = r_rd_bank;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_state_nxt = S_STREAM;
                    w_k_nxt     = '0;
                    w_valid_nxt = 1'b1;
                    w_load      = 1'b1;
                end
            end
            S_STREAM: begin
                if (w_handshake) begin
                    if (r_out_last) begin
                        w_frame_done = 1'b1;
                        w_k_nxt      = '0;
                        if (r_bank_full[~r_rd_bank]) begin
                            w_load      = 1'b1;
                            w_load_bank = ~r_rd_bank;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                        w_load  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_rd_idx  = f_order(w_k_nxt);
        w_rd_data = '0;
        if (({1'b0, w_rd_idx} < LP_FRAME) && r_bitmap[w_load_bank][w_rd_idx])
            w_rd_data = r_mem[w_load_bank][w_rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_out_valid <= w_valid_nxt;
            if (w_load) begin
                r_out_index <= w_rd_idx;
                r_out_data  <= w_rd_data;
                r_out_last  <= (w_k_nxt == LP_LAST);
            end else if (!w_valid_nxt) begin
                r_out_index <= '0;
                r_out_data  <= '0;
                r_out_last  <= 1'b0;
            end
            if (w_frame_done) begin
                r_rd_bank   <= ~r_rd_bank;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_index_o = r_out_index;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_out_last;
    assign frame_cnt_o = r_frame_cnt;
    assign overflow_o  = r_overflow;

endmodule
